// File: rtl/vmem_rect_fill.sv
// Rectangle-fill engine for the ST7789 video memory.
// The CPU programs origin/size/colour, then starts a fill. The engine clips the
// rectangle to the visible screen and emits one vmem write per cycle. It yields
// to CPU vmem stores by holding its position whenever cpu_vmem_we_i is high.
module vmem_rect_fill #(
  parameter int SCR_W = 240,
  parameter int SCR_H = 240
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        cpu_vmem_we_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [8:0] LP_W = 9'(SCR_W);
  localparam logic [8:0] LP_H = 9'(SCR_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLIP,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Programmed registers
  logic [7:0]  r_x0;
  logic [7:0]  r_y0;
  logic [8:0]  r_w;
  logic [8:0]  r_h;
  logic [2:0]  r_color;
  logic        r_done_sticky;

  // Working registers for the fill in progress
  logic [8:0]  r_cx;
  logic [8:0]  r_cy;
  logic [8:0]  r_xs;
  logic [8:0]  r_xe;
  logic [8:0]  r_ye;
  logic [2:0]  r_wcol;
  logic        r_fin;

  // Output registers
  logic        r_vmem_we;
  logic [15:0] r_vmem_addr;
  logic [2:0]  r_vmem_wdata;
  logic        r_done;
  logic [31:0] r_rdata;

  logic        w_ctrl_wr;
  logic        w_abort;
  logic        w_start;
  logic [8:0]  w_x0_ext;
  logic [8:0]  w_y0_ext;
  logic [8:0]  w_room_x;
  logic [8:0]  w_room_y;
  logic [8:0]  w_ew;
  logic [8:0]  w_eh;
  logic        w_empty;
  logic        w_emit;
  logic        w_last;
  logic        w_fin;
  logic        w_unused;

  assign w_ctrl_wr = we_i && (addr_i[3:2] == 2'd0);
  assign w_abort   = w_ctrl_wr && wdata_i[1];
  assign w_start   = w_ctrl_wr && wdata_i[0] && !wdata_i[1];

  // Clipped extents, computed from the stored registers during CLIP
  assign w_x0_ext = {1'b0, r_x0};
  assign w_y0_ext = {1'b0, r_y0};
  assign w_room_x = LP_W - w_x0_ext;
  assign w_room_y = LP_H - w_y0_ext;
  assign w_ew     = (w_x0_ext >= LP_W) ? '0 : ((r_w < w_room_x) ? r_w : w_room_x);
  assign w_eh     = (w_y0_ext >= LP_H) ? '0 : ((r_h < w_room_y) ? r_h : w_room_y);
  assign w_empty  = (w_ew == '0) || (w_eh == '0);

  assign w_emit   = (r_state == S_RUN) && !cpu_vmem_we_i;
  assign w_last   = (r_cx == r_xe) && (r_cy == r_ye);

  assign w_unused = ^{wdata_i[31:25], wdata_i[15:9], addr_i[1:0]};

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    w_fin  = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_CLIP;
      S_CLIP: begin
        if (w_empty) begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_emit && w_last) begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
      w_fin  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Programmed register file; writes land in any state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
    end else if (we_i) begin
      case (addr_i[3:2])
        2'd1: begin
          r_x0 <= wdata_i[7:0];
          r_y0 <= wdata_i[23:16];
        end
        2'd2: begin
          r_w <= wdata_i[8:0];
          r_h <= wdata_i[24:16];
        end
        2'd3: r_color <= wdata_i[2:0];
        default: ;
      endcase
    end
  end

  // Fill datapath: latch working set in CLIP, walk x then y in RUN.
  // An abort arriving in RUN still lets this cycle's pixel out; the
  // state drops to IDLE at the same edge, so writes stop the cycle after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cx         <= '0;
      r_cy         <= '0;
      r_xs         <= '0;
      r_xe         <= '0;
      r_ye         <= '0;
      r_wcol       <= '0;
      r_vmem_we    <= 1'b0;
      r_vmem_addr  <= '0;
      r_vmem_wdata <= '0;
    end else begin
      r_vmem_we <= w_emit;
      if (r_state == S_CLIP) begin
        r_cx   <= w_x0_ext;
        r_cy   <= w_y0_ext;
        r_xs   <= w_x0_ext;
        r_xe   <= w_x0_ext + w_ew - 9'd1;
        r_ye   <= w_y0_ext + w_eh - 9'd1;
        r_wcol <= r_color;
      end
      if (w_emit) begin
        r_vmem_addr  <= {r_cy[7:0], r_cx[7:0]};
        r_vmem_wdata <= r_wcol;
        if (r_cx == r_xe) begin
          r_cx <= r_xs;
          r_cy <= r_cy + 9'd1;
        end else begin
          r_cx <= r_cx + 9'd1;
        end
      end
    end
  end

  // Completion pulse trails the final action by one cycle; sticky flag follows it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fin         <= 1'b0;
      r_done        <= 1'b0;
      r_done_sticky <= 1'b0;
    end else begin
      r_fin  <= w_fin;
      r_done <= r_fin;
      if (r_fin)          r_done_sticky <= 1'b1;
      else if (w_ctrl_wr) r_done_sticky <= 1'b0;
    end
  end

  // Registered read port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
    end else begin
      case (addr_i[3:2])
        2'd0:    r_rdata <= {29'd0, r_done_sticky, (r_state != S_IDLE), 1'b0};
        2'd1:    r_rdata <= {8'd0, r_y0, 8'd0, r_x0};
        2'd2:    r_rdata <= {7'd0, r_h, 7'd0, r_w};
        default: r_rdata <= {29'd0, r_color};
      endcase
    end
  end

  assign rdata_o      = r_rdata;
  assign vmem_we_o    = r_vmem_we;
  assign vmem_addr_o  = r_vmem_addr;
  assign vmem_wdata_o = r_vmem_wdata;
  assign done_o       = r_done;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_vmem_rect_fill.sv
// Testbench for vmem_rect_fill: directed stimulus feeds a scoreboard of
// expected vmem writes and done pulses; a negedge monitor pops and compares.
module tb_vmem_rect_fill;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        cpu_vmem_we_i;
  logic        vmem_we_o;
  logic [15:0] vmem_addr_o;
  logic [2:0]  vmem_wdata_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  vmem_rect_fill #(.SCR_W(240), .SCR_H(240)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .cpu_vmem_we_i(cpu_vmem_we_i),
    .vmem_we_o    (vmem_we_o),
    .vmem_addr_o  (vmem_addr_o),
    .vmem_wdata_o (vmem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct {
    logic [15:0] a;
    logic [2:0]  d;
    int          c;
  } exp_t;

  exp_t wq[$];
  int   dq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // edge counter: after posedge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected writes / done pulses whenever the DUT presents one
  initial begin
    exp_t e;
    int   dc;
    forever begin
      @(negedge clk);
      if (vmem_we_o === 1'b1) begin
        if (wq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data %0d, want no write (cycle %0d)",
                   vmem_addr_o, vmem_wdata_o, cyc);
        end else begin
          e = wq.pop_front();
          check("wr_addr", 32'(vmem_addr_o), 32'(e.a));
          check("wr_data", 32'(vmem_wdata_o), 32'(e.d));
          check("wr_cycle", cyc, e.c);
        end
      end
      if (done_o === 1'b1) begin
        if (dq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done_o=1, want 0 (cycle %0d)", cyc);
        end else begin
          dc = dq.pop_front();
          check("done_cycle", cyc, dc);
        end
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int t);
    @(negedge clk);
    we_i = 1'b1;
    addr_i = a;
    wdata_i = d;
    @(posedge clk);
    #1;
    we_i = 1'b0;
    t = cyc;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a;
    @(posedge clk);
    #1;
    d = rdata_o;
  endtask

  task automatic push_rect(input int x0, input int y0, input int w, input int h,
                           input int col, input int t0);
    int k;
    k = 0;
    for (int y = y0; y < y0 + h; y++) begin
      for (int x = x0; x < x0 + w; x++) begin
        wq.push_back('{a: {8'(y), 8'(x)}, d: 3'(col), c: t0 + k});
        k++;
      end
    end
  endtask

  task automatic push_w(input logic [15:0] a, input logic [2:0] d, input int c);
    wq.push_back('{a: a, d: d, c: c});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(wq.size() + dq.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int          t;
    int          tmp;
    logic [31:0] r;

    rst_ni = 1'b0;
    we_i = 1'b0;
    addr_i = '0;
    wdata_i = '0;
    cpu_vmem_we_i = 1'b0;
    #12;
    check("rst_vmem_we", 32'(vmem_we_o), 32'd0);
    check("rst_vmem_addr", 32'(vmem_addr_o), 32'd0);
    check("rst_vmem_wdata", 32'(vmem_wdata_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // 1: basic 3x2 fill
    wr(4'h4, 32'h0014_000A, tmp);
    wr(4'h8, 32'h0002_0003, tmp);
    wr(4'hC, 32'h0000_0005, tmp);
    rd(4'h4, r); check("rd_origin", r, 32'h0014_000A);
    rd(4'h8, r); check("rd_size", r, 32'h0002_0003);
    rd(4'hC, r); check("rd_color", r, 32'h0000_0005);
    rd(4'h0, r); check("rd_stat_idle", r, 32'h0);
    push_rect(10, 20, 3, 2, 5, cyc + 3);
    dq.push_back(cyc + 9);
    wr(4'h0, 32'h1, t);
    check("t1_busy", 32'(busy_o), 32'd1);
    drain("t1_drain", 40);
    rd(4'h0, r); check("t1_stat", r, 32'h4);

    // 2: same fill with CPU stores at T+3 and T+4
    push_w(16'h140A, 3'd5, cyc + 3);
    push_w(16'h140B, 3'd5, cyc + 6);
    push_w(16'h140C, 3'd5, cyc + 7);
    push_w(16'h150A, 3'd5, cyc + 8);
    push_w(16'h150B, 3'd5, cyc + 9);
    push_w(16'h150C, 3'd5, cyc + 10);
    dq.push_back(cyc + 11);
    wr(4'h0, 32'h1, t);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    cpu_vmem_we_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_vmem_we_i = 1'b0;
    drain("t2_drain", 40);
    rd(4'h0, r); check("t2_stat", r, 32'h4);

    // 3: bottom-right clip to 2x1
    wr(4'h4, 32'h00EF_00EE, tmp);
    wr(4'h8, 32'h0005_0005, tmp);
    wr(4'hC, 32'h0000_0002, tmp);
    push_w(16'hEFEE, 3'd2, cyc + 3);
    push_w(16'hEFEF, 3'd2, cyc + 4);
    dq.push_back(cyc + 5);
    wr(4'h0, 32'h1, t);
    drain("t3_drain", 40);

    // 4: origin off-screen -> no writes, done two cycles after start
    wr(4'h4, 32'h0000_00F0, tmp);
    wr(4'h8, 32'h0004_0004, tmp);
    dq.push_back(cyc + 3);
    wr(4'h0, 32'h1, t);
    drain("t4_drain", 40);
    rd(4'h0, r); check("t4_stat", r, 32'h4);

    // 5: full-screen fill aborted at T+100, then a fresh small fill
    wr(4'h4, 32'h0000_0000, tmp);
    wr(4'h8, 32'h00F0_00F0, tmp);
    wr(4'hC, 32'h0000_0003, tmp);
    push_rect(0, 0, 99, 1, 3, cyc + 3);
    wr(4'h0, 32'h1, t);
    do @(negedge clk); while (cyc < t + 98);
    wr(4'h0, 32'h2, tmp);
    check("t5_busy_after_abort", 32'(busy_o), 32'd0);
    drain("t5_drain", 200);
    rd(4'h0, r); check("t5_stat", r, 32'h0);
    wr(4'h8, 32'h0002_0002, tmp);
    push_rect(0, 0, 2, 2, 3, cyc + 3);
    dq.push_back(cyc + 7);
    wr(4'h0, 32'h1, t);
    drain("t5b_drain", 40);

    // 6: asynchronous reset mid-fill
    wr(4'h8, 32'h00F0_00F0, tmp);
    push_rect(0, 0, 9, 1, 3, cyc + 3);
    wr(4'h0, 32'h1, t);
    do @(negedge clk); while (cyc < t + 10);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_we", 32'(vmem_we_o), 32'd0);
    check("t6_addr", 32'(vmem_addr_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_rdata", rdata_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    rd(4'h0, r); check("t6_rd_stat", r, 32'h0);
    rd(4'h4, r); check("t6_rd_origin", r, 32'h0);
    rd(4'h8, r); check("t6_rd_size", r, 32'h0);
    rd(4'hC, r); check("t6_rd_color", r, 32'h0);
    drain("t6_drain", 10);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
